bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3) that feeds the 6-digit multiplexed seven-segment display driver. It accepts a binary value with a start/done handshake and converts it over BIN_W cycles. It produces a registered 24-bit packed BCD word whose digit 0 is in [3:0] and digit 5 is in [23:20]. The word holds steady between conversions, so the display refresh never shows a partial result.

## Interface
- BIN_W, default 20: binary input width; range 4..20.
- DIGITS, default 6: number of BCD output digits; the packed output is 4*DIGITS bits wide.
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; asynchronous, active-high.
- bin_in  input  BIN_W  binary value; sampled only on an accepted start.
- start  input  1  conversion request; accepted only in IDLE.
- busy  output  1  high from the cycle after acceptance until done is asserted.
- done  output  1  one-cycle pulse; bcd_out is valid on the same cycle.
- ovf  output  1  registered; set when the last accepted value exceeded 10^DIGITS-1.
- bcd_out  output  4*DIGITS  packed BCD result; held until the next done.

## Operation
- States:
  - IDLE: on start, latch bin_in into shift register sr and clear the BCD scratch register bs.
    - Set cnt=BIN_W.
    - Compute sat = (bin_in > MAX), where MAX = 10^DIGITS-1 is a localparam.
    - Go to SHIFT.
  - SHIFT: each cycle, every 4-bit digit of bs that is ≥5 gets +3; then {bs,sr} shifts left by 1 and cnt decrements. When cnt reaches 1 in this cycle, go to FIN.
  - FIN: bcd_out <= sat ? all digits 9 : bs (blanking per Configuration); ovf <= sat; done=1; go to IDLE.
- start in SHIFT or FIN is ignored; it is not queued.
- start asserted continuously in IDLE re-triggers a conversion back-to-back: FIN→IDLE→accept.
- bin_in changing during SHIFT has no effect.
- Digit adjust uses 4-bit arithmetic; the result never exceeds 4'hC before the shift.
- Carries out of the top digit are discarded. They only occur in the saturated case, which is overridden.
- Reset values: state=IDLE, busy=0, done=0, ovf=0, bcd_out=all zeros (or blank code per Configuration), cnt=0.
- rst asserted mid-conversion aborts immediately to reset values. No done is produced.

## Timing
- Start accepted on edge E0. busy is high from after E0 until after E(BIN_W+1).
- done and the new bcd_out/ovf are visible after E(BIN_W+1). Latency is BIN_W+1 cycles: 21 cycles at the defaults.
- Earliest next acceptance is at edge E(BIN_W+2). Throughput is one conversion per BIN_W+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- BIN2BCD_BLANK_EN:
  - Defined: at FIN, leading zero digits (most significant first, down to but excluding digit 0) are replaced with 4'hF. 4'hF is the display decoder's all-segments-off code. Reset value of bcd_out is 4'hF in digits 5..1 and 4'h0 in digit 0.
  - Undefined: leading zeros are output as 4'h0. Reset bcd_out is all zeros.
  - Saturated results are never blanked.

## Structure
- Shared package `bin2bcd_pkg`:
  - state encoding (IDLE, SHIFT, FIN);
  - BCD_BLANK = 4'hF;
  - BCD_DIGIT_W = 4.
- Sub-module `bcd_add3`: combinational 4-bit digit adjust (in≥5 ? in+3 : in). It is instantiated DIGITS times via generate.
- cnt width is $clog2(BIN_W+1).

## Test plan
- Reset, then bin_in=0, start for 1 cycle:
  - Macro off: done after 21 cycles, bcd_out=24'h000000, ovf=0.
  - Macro on: bcd_out=24'hFFFFF0.
- bin_in=123456 → bcd_out=24'h123456, ovf=0, done exactly 21 cycles after acceptance, busy high for 21 cycles. With the macro on, bin_in=907 → 24'hFFF907.
- bin_in=999999 → 24'h999999, ovf=0. bin_in=1000000 and bin_in=20'hFFFFF → 24'h999999, ovf=1.
- Change bin_in and pulse start while busy → result reflects the original value, the second start is ignored, and exactly one done is produced.
- start held high with bin_in=42 → done pulses every 22 cycles, and bcd_out stays 24'h000042 (macro off).
- Assert rst at cycle 10 of a conversion of 555555 → outputs return to reset values at once and no done appears. A fresh start then yields 24'h555555.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM encoding, BCD digit constants and a constant-time power-of-ten helper.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFin
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_NINE    = 4'h9;

    // Elaboration-time 10^n, used to derive the saturation threshold.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] acc;
        acc = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit adjust for the shift-and-add-3 algorithm: digits of 5..9 get +3
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/done handshake.
// Define BIN2BCD_BLANK_EN to blank leading zero digits with the display's all-off code.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 20,
    parameter int unsigned DIGITS = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [BIN_W-1:0]                bin_in,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            ovf,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    localparam logic [63:0]      MAX_VAL  = pow10(DIGITS) - 64'd1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
    localparam logic [BCD_W-1:0] SAT_WORD = {DIGITS{BCD_NINE}};
`ifdef BIN2BCD_BLANK_EN
    localparam logic [BCD_W-1:0] RST_WORD = {{(DIGITS - 1){BCD_BLANK}}, 4'h0};
`else
    localparam logic [BCD_W-1:0] RST_WORD = '0;
`endif

    state_t           state_q;
    logic [BIN_W-1:0] sr_q;
    logic [BCD_W-1:0] bs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;

    logic [BCD_W-1:0] bs_adj;
    logic [BCD_W-1:0] blanked;
    logic [BCD_W-1:0] fin_word;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .digit    (bs_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (bs_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BIN2BCD_BLANK_EN
    logic leading;

    // Blank from the top down until the first non-zero digit; digit 0 always shows.
    always_comb begin
        blanked = bs_q;
        leading = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (leading && bs_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'h0) begin
                blanked[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    always_comb begin
        blanked = bs_q;
    end
`endif

    always_comb begin
        fin_word = sat_q ? SAT_WORD : blanked;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            bs_q    <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            bcd_out <= RST_WORD;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        sr_q    <= bin_in;
                        bs_q    <= '0;
                        cnt_q   <= CNT_INIT;
                        sat_q   <= 64'(bin_in) > MAX_VAL;
                        busy    <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    // Carry out of the top digit drops off here; only reachable when saturated.
                    {bs_q, sr_q} <= {bs_adj, sr_q} << 1;
                    cnt_q        <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    bcd_out <= fin_word;
                    ovf     <= sat_q;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic reference model.
// Honours BIN2BCD_BLANK_EN in the model the same way the design does.
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W  = 20;
    localparam int unsigned DIGITS = 6;
    localparam int unsigned LAT    = BIN_W + 1;

`ifdef BIN2BCD_BLANK_EN
    localparam logic [23:0] RST_WORD = 24'hFFFFF0;
`else
    localparam logic [23:0] RST_WORD = 24'h000000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [19:0] bin_in = '0;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [23:0] bcd_out;

    int unsigned total = 0;
    int unsigned bad = 0;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bin_in  (bin_in),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .bcd_out (bcd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_word(input int unsigned v);
        logic [23:0] w;
        int unsigned t;
        bit          lead;
        if (v > 999999) return 24'h999999;
        t = v;
        for (int i = 0; i < 6; i++) begin
            w[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        lead = 1'b1;
`ifdef BIN2BCD_BLANK_EN
        for (int i = 5; i >= 1; i--) begin
            if (lead && w[i*4 +: 4] == 4'h0) w[i*4 +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Assumes the DUT is idle on entry; leaves it idle on exit.
    task automatic run_conv(input int unsigned v);
        int unsigned cyc;
        int unsigned busy_cnt;
        bit          got;
        bin_in = 20'(v);
        start  = 1'b1;
        tick();
        start    = 1'b0;
        bin_in   = 20'($urandom);
        cyc      = 0;
        busy_cnt = busy ? 1 : 0;
        got      = 1'b0;
        while (cyc < 40 && !got) begin
            tick();
            cyc++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("latency", cyc, LAT);
            check("busy_cycles", busy_cnt, LAT);
            check("busy_at_done", 32'(busy), 32'd0);
            check("bcd_out", 32'(bcd_out), 32'(exp_word(v)));
            check("ovf", 32'(ovf), (v > 999999) ? 32'd1 : 32'd0);
            tick();
            check("done_pulse", 32'(done), 32'd0);
            check("bcd_hold", 32'(bcd_out), 32'(exp_word(v)));
        end
    endtask

    initial begin
        int unsigned nd;
        int unsigned last;
        int unsigned v;

        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'(RST_WORD));
        rst = 1'b0;
        tick();
        check("idle_bcd", 32'(bcd_out), 32'(RST_WORD));

        run_conv(0);
        run_conv(123456);
        run_conv(907);
        run_conv(999999);
        run_conv(1000000);
        run_conv(20'hFFFFF);

        for (int i = 0; i < 16; i++) begin
            v = (i % 2 == 0) ? $urandom_range(0, 20'hFFFFF) : $urandom_range(0, 999);
            run_conv(v);
        end

        // Second start and bin_in change while busy must be ignored.
        bin_in = 20'd314159;
        start  = 1'b1;
        tick();
        start = 1'b0;
        nd    = 0;
        for (int c = 1; c <= 35; c++) begin
            if (c == 5) begin
                bin_in = 20'd271828;
                start  = 1'b1;
            end
            if (c == 7) start = 1'b0;
            tick();
            if (done) begin
                nd++;
                check("ign_cycle", c, LAT);
                check("ign_bcd", 32'(bcd_out), 32'(exp_word(314159)));
            end
        end
        check("ign_count", nd, 32'd1);

        // Held start: back-to-back conversions every BIN_W+2 cycles.
        bin_in = 20'd42;
        start  = 1'b1;
        tick();
        nd   = 0;
        last = 0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (done) begin
                nd++;
                check("bb_gap", c - last, (nd == 1) ? LAT : LAT + 1);
                check("bb_bcd", 32'(bcd_out), 32'(exp_word(42)));
                last = c;
                if (nd == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        check("bb_count", nd, 32'd3);
        tick();
        check("bb_stop_busy", 32'(busy), 32'd0);

        // Leave ovf set so the mid-conversion reset has something to clear.
        run_conv(20'hFFFFF);
        bin_in = 20'd555555;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'(RST_WORD));
        #2;
        rst = 1'b0;
        nd  = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done) nd++;
        end
        check("abort_no_done", nd, 32'd0);
        run_conv(555555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
